// File: rtl/fir_mac_engine_if.sv
// Bus bundle for fir_mac_engine: sample handshake, control, ROM port and output frame.
interface fir_mac_engine_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 1021,
    parameter int CH     = 2,
    parameter int BANK_W = 2
);
    localparam int ADDR_W = BANK_W + $clog2(TAPS);

    logic                   smpl_vld;
    logic [CH*DATA_W-1:0]   smpl_in;
    logic [BANK_W-1:0]      coef_bank;
    logic                   bypass;
    logic [ADDR_W-1:0]      coef_addr;
    logic [COEF_W-1:0]      coef_data;
    logic                   busy;
    logic                   out_vld;
    logic [CH*DATA_W-1:0]   smpl_out;
    logic                   ovrn;

    // Engine side
    modport slave (
        input  smpl_vld, smpl_in, coef_bank, bypass, coef_data,
        output coef_addr, busy, out_vld, smpl_out, ovrn
    );

    // Sample source / ROM side
    modport master (
        output smpl_vld, smpl_in, coef_bank, bypass, coef_data,
        input  coef_addr, busy, out_vld, smpl_out, ovrn
    );
endinterface

// File: rtl/fir_mac_engine.sv
// Multi-channel FIR engine: per-channel circular history, sequential MAC against
// an external synchronous coefficient ROM, saturated output frame per input frame.
module fir_mac_engine #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 1021,
    parameter int CH     = 2,
    parameter int BANK_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    fir_mac_engine_if.slave   bus
);
    localparam int PTR_W  = $clog2(TAPS);
    localparam int FILL_W = $clog2(TAPS + 1);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + PTR_W;
    localparam logic [PTR_W-1:0]         LAST    = PTR_W'(TAPS - 1);
    localparam logic signed [ACC_W-1:0]  SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_e;
    state_e state_q, state_d;

    logic                      accept;
    logic [PTR_W-1:0]          wr_ptr_q;
    logic [FILL_W-1:0]         fill_q;
    logic [PTR_W-1:0]          rd_idx_q;
    logic [PTR_W-1:0]          k_q;
    logic [BANK_W-1:0]         bank_q;
    logic                      byp_q;
    logic [CH*DATA_W-1:0]      frame_q;
    logic [BANK_W+PTR_W-1:0]   coef_addr_q;
    logic                      acc_en_q;
    logic                      tap_ok_q;
    logic                      out_vld_q;
    logic                      ovrn_q;
    logic [CH*DATA_W-1:0]      smpl_out_q;
    logic [CH*DATA_W-1:0]      sat_frame;

    logic [DATA_W-1:0]         hist_q    [CH][TAPS];
    logic [DATA_W-1:0]         hist_rd_q [CH];
    logic signed [ACC_W-1:0]   acc_q     [CH];
    logic signed [PROD_W-1:0]  prod      [CH];
    logic signed [ACC_W-1:0]   shr       [CH];

    assign accept        = bus.smpl_vld && (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_vld   = out_vld_q;
    assign bus.ovrn      = ovrn_q;
    assign bus.smpl_out  = smpl_out_q;
    assign bus.coef_addr = coef_addr_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: accept -> issue TAPS addresses -> final accumulate -> emit
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (k_q == LAST) state_d = DRAIN;
            DRAIN:   state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control path: pointers, tap sequencing, ROM address, output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            rd_idx_q    <= '0;
            k_q         <= '0;
            bank_q      <= '0;
            byp_q       <= 1'b0;
            frame_q     <= '0;
            coef_addr_q <= '0;
            acc_en_q    <= 1'b0;
            tap_ok_q    <= 1'b0;
            out_vld_q   <= 1'b0;
            ovrn_q      <= 1'b0;
            smpl_out_q  <= '0;
        end else begin
            ovrn_q    <= bus.smpl_vld && (state_q != IDLE);
            out_vld_q <= 1'b0;
            // ROM data and history read for the tap issued this cycle land next cycle
            acc_en_q  <= (state_q == RUN);
            if (accept) begin
                wr_ptr_q    <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
                if (fill_q != FILL_W'(TAPS)) fill_q <= fill_q + 1'b1;
                rd_idx_q    <= wr_ptr_q;
                k_q         <= '0;
                bank_q      <= bus.coef_bank;
                byp_q       <= bus.bypass;
                frame_q     <= bus.smpl_in;
                coef_addr_q <= {bus.coef_bank, PTR_W'(0)};
            end
            if (state_q == RUN) begin
                tap_ok_q <= (FILL_W'(k_q) < fill_q);
                if (k_q != LAST) begin
                    k_q         <= k_q + 1'b1;
                    rd_idx_q    <= (rd_idx_q == '0) ? LAST : rd_idx_q - 1'b1;
                    coef_addr_q <= {bank_q, k_q + 1'b1};
                end
            end
            if (state_q == OUT) begin
                out_vld_q  <= 1'b1;
                smpl_out_q <= byp_q ? frame_q : sat_frame;
            end
        end
    end

    // History buffer write on acceptance and synchronous read aligned with ROM latency
    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < CH; c++) begin
            if (accept) hist_q[c][wr_ptr_q] <= bus.smpl_in[c*DATA_W +: DATA_W];
            hist_rd_q[c] <= hist_q[c][rd_idx_q];
        end
    end

    // Per-channel signed product of history sample and coefficient
    always_comb begin
        for (int unsigned c = 0; c < CH; c++) begin
            prod[c] = $signed(hist_rd_q[c]) * $signed(bus.coef_data);
        end
    end

    // Accumulators: cleared on acceptance, taps beyond fill are skipped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < CH; c++) acc_q[c] <= '0;
        end else begin
            for (int unsigned c = 0; c < CH; c++) begin
                if (accept)
                    acc_q[c] <= '0;
                else if (acc_en_q && tap_ok_q)
                    acc_q[c] <= acc_q[c] + {{PTR_W{prod[c][PROD_W-1]}}, prod[c]};
            end
        end
    end

    // Rescale (floor) and saturate each accumulator into the output frame
    always_comb begin
        sat_frame = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            shr[c] = acc_q[c] >>> (COEF_W - 1);
            if (shr[c] > SAT_MAX)
                sat_frame[c*DATA_W +: DATA_W] = SAT_MAX[DATA_W-1:0];
            else if (shr[c] < SAT_MIN)
                sat_frame[c*DATA_W +: DATA_W] = SAT_MIN[DATA_W-1:0];
            else
                sat_frame[c*DATA_W +: DATA_W] = shr[c][DATA_W-1:0];
        end
    end
endmodule

// File: tb/tb_fir_mac_engine.sv
// Scoreboard bench for fir_mac_engine (TAPS=8, CH=2) with a behavioural synchronous ROM.
module tb_fir_mac_engine;
    localparam int TAPS = 8;
    localparam int LAT  = TAPS + 3;

    typedef struct {
        logic [31:0] frame;
        int          acc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sbq [$];
    exp_t mon_e;
    logic [15:0] rom [32];

    fir_mac_engine_if #(.DATA_W(16), .COEF_W(16), .TAPS(TAPS), .CH(2), .BANK_W(2)) bus ();

    fir_mac_engine #(.DATA_W(16), .COEF_W(16), .TAPS(TAPS), .CH(2), .BANK_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous coefficient ROM, one cycle latency
    always @(posedge clk) bus.coef_data <= rom[bus.coef_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: every out_vld pops one expectation; latency counts the edge ending the pulse
    always @(negedge clk) begin
        if (bus.out_vld === 1'b1) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out_vld: got out_vld=1 smpl_out=%h expected no output", bus.smpl_out);
            end else begin
                mon_e = sbq.pop_front();
                check("smpl_out", bus.smpl_out, mon_e.frame);
                check("latency", 32'(cyc + 1 - mon_e.acc), 32'(LAT));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL busy_timeout: got busy=1 after 100 cycles expected 0");
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending outputs expected 0", sbq.size());
        end
    endtask

    // Drive one frame; bank/bypass are scrambled right after acceptance
    task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input logic [1:0] bank,
                              input logic byp, input bit expect_out,
                              input logic [15:0] ea, input logic [15:0] eb);
        exp_t e;
        @(negedge clk);
        wait_idle();
        bus.smpl_in   = {b, a};
        bus.coef_bank = bank;
        bus.bypass    = byp;
        bus.smpl_vld  = 1'b1;
        if (expect_out) begin
            e.frame = {eb, ea};
            e.acc   = cyc + 1;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.smpl_vld  = 1'b0;
        bus.coef_bank = ~bank;
        bus.bypass    = ~byp;
        bus.smpl_in   = 32'hDEAD_BEEF;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000 expected earlier finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.smpl_vld  = 1'b0;
        bus.smpl_in   = '0;
        bus.coef_bank = '0;
        bus.bypass    = 1'b0;
        rom_clear();
        #1 rst_n = 1'b0;
        #12;
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_out_vld",   32'(bus.out_vld),   32'd0);
        check("rst_ovrn",      32'(bus.ovrn),      32'd0);
        check("rst_smpl_out",  bus.smpl_out,       32'd0);
        check("rst_coef_addr", 32'(bus.coef_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Impulse: 8 taps of 0.5 -> 0.25 for 8 outputs, then zero
        for (int k = 0; k < TAPS; k++) rom[k] = 16'h4000;
        send_frame(16'h4000, 16'h4000, 2'd0, 1'b0, 1, 16'h2000, 16'h2000);
        for (int i = 1; i < 10; i++) begin
            if (i < TAPS) send_frame(16'h0000, 16'h0000, 2'd0, 1'b0, 1, 16'h2000, 16'h2000);
            else          send_frame(16'h0000, 16'h0000, 2'd0, 1'b0, 1, 16'h0000, 16'h0000);
        end
        wait_drain();

        // Saturation: ch0 full-scale positive, ch1 full-scale negative
        do_reset();
        send_frame(16'h7FFF, 16'h8000, 2'd0, 1'b0, 1, 16'h3FFF, 16'hC000);
        for (int i = 1; i < 8; i++) send_frame(16'h7FFF, 16'h8000, 2'd0, 1'b0, 1, 16'h7FFF, 16'h8000);
        wait_drain();

        // Bank select and fill gating over stale history
        do_reset();
        rom[8] = 16'h7FFF;
        send_frame(16'h1000, 16'h1000, 2'd1, 1'b0, 1, 16'h0FFF, 16'h0FFF);
        send_frame(16'h1000, 16'h1000, 2'd0, 1'b0, 1, 16'h1000, 16'h1000);
        wait_drain();

        // Bypass, then an overrun attempt, then an impulse seeing only accepted history
        do_reset();
        send_frame(16'h1234, 16'h5678, 2'd0, 1'b1, 1, 16'h1234, 16'h5678);
        repeat (3) @(negedge clk);
        bus.smpl_in  = {16'h7000, 16'h7000};
        bus.smpl_vld = 1'b1;
        @(posedge clk);
        #1 bus.smpl_vld = 1'b0;
        @(negedge clk);
        check("ovrn_pulse", 32'(bus.ovrn), 32'd1);
        check("busy_during_run", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("ovrn_one_cycle", 32'(bus.ovrn), 32'd0);
        send_frame(16'h4000, 16'h4000, 2'd0, 1'b0, 1, 16'h291A, 16'h4B3C);
        wait_drain();

        // Wrap-around ramp: taps 0 and 7 at ~1.0
        do_reset();
        rom_clear();
        rom[0] = 16'h7FFF;
        rom[7] = 16'h7FFF;
        for (int n = 1; n <= 20; n++) begin
            send_frame(16'(n), 16'(2 * n), 2'd0, 1'b0, 1,
                       (n <= 7) ? 16'(n - 1)     : 16'(2 * n - 8),
                       (n <= 7) ? 16'(2 * n - 1) : 16'(4 * n - 15));
        end
        wait_drain();

        // Reset in the middle of RUN aborts the frame
        for (int k = 0; k < TAPS; k++) rom[k] = 16'h4000;
        send_frame(16'h4000, 16'h4000, 2'd0, 1'b0, 0, 16'h0000, 16'h0000);
        repeat (4) @(posedge clk);
        #2;
        check("busy_before_abort", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy",      32'(bus.busy),      32'd0);
        check("abort_out_vld",   32'(bus.out_vld),   32'd0);
        check("abort_smpl_out",  bus.smpl_out,       32'd0);
        check("abort_coef_addr", 32'(bus.coef_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(16'h4000, 16'h4000, 2'd0, 1'b0, 1, 16'h2000, 16'h2000);
        wait_drain();

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
